// File: rtl/hex_fmt_pkg.sv
// ---------------------------------------------------------------------------
// hex_fmt_pkg
// Shared definitions for the hex ASCII formatter:
//   - state_t          : frame sequencing states (IDLE, DIGIT, CR, LF)
//   - ASCII_CR/ASCII_LF: line terminator bytes
//   - ASCII_ZERO, ASCII_UPPER_A, ASCII_LOWER_A : digit code bases
//   - nibble_to_ascii(): 4-bit value to ASCII hex digit, case selectable
// ---------------------------------------------------------------------------
package hex_fmt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DIGIT = 2'd1,
        ST_CR    = 2'd2,
        ST_LF    = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_ZERO    = 8'h30;
    localparam logic [7:0] ASCII_UPPER_A = 8'h41;
    localparam logic [7:0] ASCII_LOWER_A = 8'h61;

    // Values 0-9 map onto '0'..'9'; 10-15 map onto 'A'..'F' or 'a'..'f'.
    function automatic logic [7:0] nibble_to_ascii(
        input logic [3:0] nibble,
        input logic       uppercase
    );
        logic [7:0] w_base;
        logic [7:0] w_nib8;
        w_nib8 = {4'h0, nibble};
        if (nibble < 4'd10) begin
            nibble_to_ascii = ASCII_ZERO + w_nib8;
        end else begin
            w_base          = uppercase ? ASCII_UPPER_A : ASCII_LOWER_A;
            nibble_to_ascii = w_base + (w_nib8 - 8'd10);
        end
    endfunction

endpackage : hex_fmt_pkg

// File: rtl/hex_ascii_formatter.sv
// ---------------------------------------------------------------------------
// hex_ascii_formatter
// Takes one result word per frame on an AXI-Stream slave and emits it as
// DATA_WIDTH/4 ASCII hex digits (most-significant nibble first) on an
// AXI-Stream master, optionally followed by CR LF. Only one word is held at a
// time: the slave side is ready only while the block is idle.
//
// Parameters
//   DATA_WIDTH   : input word width, multiple of 4, >= 4
//   INCLUDE_CRLF : 1 -> append 8'h0D 8'h0A to every frame
//   UPPERCASE    : 1 -> digits A-F as 8'h41-8'h46, 0 -> 8'h61-8'h66
//
// Ports
//   aclk_i           in   clock, all flops on rising edge
//   rst_i            in   synchronous active-high reset
//   s_axis_tready_o  out  ready for a new word (high only in IDLE)
//   s_axis_tdata_i   in   result word
//   s_axis_tvalid_i  in   result word valid
//   s_axis_tlast_i   in   accepted and ignored
//   m_axis_tvalid_o  out  ASCII byte valid
//   m_axis_tdata_o   out  ASCII byte
//   m_axis_tlast_o   out  final byte of the frame
//   m_axis_tready_i  in   downstream ready
// ---------------------------------------------------------------------------
module hex_ascii_formatter
    import hex_fmt_pkg::*;
#(
    parameter int DATA_WIDTH   = 16,
    parameter int INCLUDE_CRLF = 1,
    parameter int UPPERCASE    = 1
) (
    input  logic                  aclk_i,
    input  logic                  rst_i,
    output logic                  s_axis_tready_o,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata_i,
    input  logic                  s_axis_tvalid_i,
    input  logic                  s_axis_tlast_i,
    output logic                  m_axis_tvalid_o,
    output logic [7:0]            m_axis_tdata_o,
    output logic                  m_axis_tlast_o,
    input  logic                  m_axis_tready_i
);

    localparam int NDIG  = DATA_WIDTH / 4;
    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NDIG - 1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t                r_state;
    logic [IDX_W-1:0]      r_idx;
    logic [DATA_WIDTH-1:0] r_word;

    state_t                w_state_nxt;
    logic [IDX_W-1:0]      w_idx_nxt;
    logic [DATA_WIDTH-1:0] w_word_nxt;

    logic                  w_m_xfer;
    logic [DATA_WIDTH-1:0] w_word_shifted;
    logic [3:0]            w_nibble;

    // The upstream frame delimiter has no meaning here; every word is a frame.
    logic                  w_unused_tlast;
    assign w_unused_tlast = s_axis_tlast_i;

    // A downstream transfer is only possible while a byte is presented, so
    // tvalid is implied by the state tests in the next-state logic below.
    assign w_m_xfer = m_axis_tready_i;

    // Select the current digit by shifting it down to the bottom nibble.
    assign w_word_shifted = r_word >> {r_idx, 2'b00};
    assign w_nibble       = w_word_shifted[3:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop, matching hardware.
    always_ff @(posedge aclk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_word  <= w_word_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first; any path that
    // left one unassigned would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_word_nxt  = r_word;

        unique case (r_state)
            ST_IDLE: begin
                if (s_axis_tvalid_i) begin
                    w_word_nxt  = s_axis_tdata_i;
                    w_idx_nxt   = IDX_LAST;
                    w_state_nxt = ST_DIGIT;
                end
            end
            ST_DIGIT: begin
                if (w_m_xfer) begin
                    if (r_idx != '0) begin
                        w_idx_nxt = r_idx - 1'b1;
                    end else if (INCLUDE_CRLF != 0) begin
                        w_state_nxt = ST_CR;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            ST_CR: begin
                if (w_m_xfer) begin
                    w_state_nxt = ST_LF;
                end
            end
            ST_LF: begin
                if (w_m_xfer) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output decode: a function of registered state only, so downstream
    // tready never reaches s_axis_tready_o or m_axis_tvalid_o.
    // ------------------------------------------------------------------
    always_comb begin
        s_axis_tready_o = 1'b0;
        m_axis_tvalid_o = 1'b0;
        m_axis_tdata_o  = 8'h00;
        m_axis_tlast_o  = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                s_axis_tready_o = 1'b1;
            end
            ST_DIGIT: begin
                m_axis_tvalid_o = 1'b1;
                m_axis_tdata_o  = nibble_to_ascii(w_nibble, UPPERCASE != 0);
                m_axis_tlast_o  = (INCLUDE_CRLF == 0) && (r_idx == '0);
            end
            ST_CR: begin
                m_axis_tvalid_o = 1'b1;
                m_axis_tdata_o  = ASCII_CR;
            end
            ST_LF: begin
                m_axis_tvalid_o = 1'b1;
                m_axis_tdata_o  = ASCII_LF;
                m_axis_tlast_o  = 1'b1;
            end
            default: begin
                s_axis_tready_o = 1'b0;
            end
        endcase
    end

endmodule : hex_ascii_formatter

// File: tb/tb_hex_ascii_formatter.sv
// ---------------------------------------------------------------------------
// tb_hex_ascii_formatter
// Three formatter instances (defaults, lowercase, no CR LF) share one clock
// and reset. Stimulus pushes each word's expected frame into a per-instance
// queue; a monitor per instance pops and compares on every downstream
// transfer, and also checks stall stability and post-frame idle behaviour.
// ---------------------------------------------------------------------------
module tb_hex_ascii_formatter;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    logic             aclk;
    logic             rst;
    logic [2:0]       s_tready;
    logic [2:0][15:0] s_tdata;
    logic [2:0]       s_tvalid;
    logic [2:0]       s_tlast;
    logic [2:0]       m_tvalid;
    logic [2:0][7:0]  m_tdata;
    logic [2:0]       m_tlast;
    logic [2:0]       m_tready;
    logic [2:0]       rand_ready;

    beat_t exp_q [3][$];
    int    nxfer [3];
    int    last_xfer_cyc [3];
    int    cyc;
    int    checks;
    int    failures;

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: frame for one word, from the textual rules.
    task automatic push_frame(input int k, input logic [15:0] w);
        bit up;
        bit crlf;
        beat_t b;
        int nib;
        up   = (k != 1);
        crlf = (k != 2);
        for (int d = 3; d >= 0; d--) begin
            nib    = (int'(w) >> (4 * d)) & 15;
            b.data = (nib < 10) ? 8'(48 + nib) : 8'((up ? 65 : 97) + nib - 10);
            b.last = !crlf && (d == 0);
            exp_q[k].push_back(b);
        end
        if (crlf) begin
            b.data = 8'h0D; b.last = 1'b0; exp_q[k].push_back(b);
            b.data = 8'h0A; b.last = 1'b1; exp_q[k].push_back(b);
        end
    endtask

    // Downstream ready: held high, or random 50% per cycle.
    initial begin
        m_tready = 3'b111;
        forever begin
            @(posedge aclk);
            #1;
            for (int k = 0; k < 3; k++)
                m_tready[k] = rand_ready[k] ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hex_ascii_formatter #(
            .DATA_WIDTH   (16),
            .INCLUDE_CRLF ((g == 2) ? 0 : 1),
            .UPPERCASE    ((g == 1) ? 0 : 1)
        ) u_dut (
            .aclk_i          (aclk),
            .rst_i           (rst),
            .s_axis_tready_o (s_tready[g]),
            .s_axis_tdata_i  (s_tdata[g]),
            .s_axis_tvalid_i (s_tvalid[g]),
            .s_axis_tlast_i  (s_tlast[g]),
            .m_axis_tvalid_o (m_tvalid[g]),
            .m_axis_tdata_o  (m_tdata[g]),
            .m_axis_tlast_o  (m_tlast[g]),
            .m_axis_tready_i (m_tready[g])
        );

        logic       stall_q;
        logic [7:0] stall_data;
        logic       stall_last;
        logic       idle_due;
        beat_t      e;

        initial begin
            stall_q  = 1'b0;
            idle_due = 1'b0;
        end

        always @(negedge aclk) begin
            if (rst) begin
                exp_q[g].delete();
                stall_q  <= 1'b0;
                idle_due <= 1'b0;
            end else begin
                if (idle_due)
                    check($sformatf("idle_after_last[%0d]", g), {30'd0, m_tvalid[g], s_tready[g]}, 32'd1);
                if (stall_q)
                    check($sformatf("stall_hold[%0d]", g),
                          {22'd0, m_tvalid[g], m_tlast[g], m_tdata[g]},
                          {22'd0, 1'b1, stall_last, stall_data});
                if (m_tvalid[g])
                    check($sformatf("s_ready_low_in_frame[%0d]", g), {31'd0, s_tready[g]}, 32'd0);
                if (m_tvalid[g] && m_tready[g]) begin
                    check($sformatf("beat_expected[%0d]", g), {31'd0, exp_q[g].size() != 0}, 32'd1);
                    if (exp_q[g].size() != 0) begin
                        e = exp_q[g].pop_front();
                        check($sformatf("beat[%0d]", g), {23'd0, m_tdata[g], m_tlast[g]}, {23'd0, e.data, e.last});
                    end
                    nxfer[g] <= nxfer[g] + 1;
                    if (m_tlast[g]) last_xfer_cyc[g] <= cyc;
                end
                idle_due   <= m_tvalid[g] && m_tready[g] && m_tlast[g];
                stall_q    <= m_tvalid[g] && !m_tready[g];
                stall_data <= m_tdata[g];
                stall_last <= m_tlast[g];
            end
        end
    end

    // Offer a word and wait (bounded) for acceptance. hold keeps tvalid high
    // afterwards; b2b checks acceptance one cycle after the last frame end.
    task automatic send_word(input int k, input logic [15:0] w, input bit hold, input bit b2b);
        bit acc;
        int acc_cyc;
        acc = 1'b0;
        s_tvalid[k] = 1'b1;
        s_tdata[k]  = w;
        s_tlast[k]  = 1'($urandom_range(0, 1));
        for (int n = 0; n < 200 && !acc; n++) begin
            @(negedge aclk);
            if (s_tready[k] && !rst) begin
                acc     = 1'b1;
                acc_cyc = cyc;
                push_frame(k, w);
                @(posedge aclk);
                #1;
                check($sformatf("first_digit_latency[%0d]", k), {31'd0, m_tvalid[k]}, 32'd1);
                if (b2b)
                    check($sformatf("b2b_accept_cycle[%0d]", k), acc_cyc, last_xfer_cyc[k] + 1);
            end
        end
        check($sformatf("accept_timeout[%0d]", k), {31'd0, acc}, 32'd1);
        if (!hold) s_tvalid[k] = 1'b0;
        s_tdata[k] = 16'($urandom);
    endtask

    task automatic wait_drain(input int k);
        int n;
        n = 0;
        while ((exp_q[k].size() != 0 || m_tvalid[k]) && n < 1000) begin
            @(posedge aclk);
            #1;
            n++;
        end
        check($sformatf("drain_timeout[%0d]", k), {31'd0, n < 1000}, 32'd1);
    endtask

    initial begin
        int base;
        checks     = 0;
        failures   = 0;
        rand_ready = 3'b000;
        s_tvalid   = '0;
        s_tdata    = '0;
        s_tlast    = '0;
        for (int k = 0; k < 3; k++) begin
            nxfer[k]         = 0;
            last_xfer_cyc[k] = -10;
        end
        rst = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        for (int k = 0; k < 3; k++)
            check($sformatf("reset_outputs[%0d]", k),
                  {21'd0, s_tready[k], m_tvalid[k], m_tlast[k], m_tdata[k]},
                  {21'd0, 1'b1, 1'b0, 1'b0, 8'h00});
        rst = 1'b0;
        @(posedge aclk);
        #1;

        // Directed frames with ready held high.
        send_word(0, 16'h1A2F, 1'b0, 1'b0); wait_drain(0);
        send_word(1, 16'hBEEF, 1'b0, 1'b0); wait_drain(1);
        send_word(2, 16'h0009, 1'b0, 1'b0); wait_drain(2);

        // Stalled downstream.
        rand_ready[0] = 1'b1;
        send_word(0, 16'hC0DE, 1'b0, 1'b0); wait_drain(0);
        rand_ready[0] = 1'b0;

        // Back-to-back words with tvalid held.
        send_word(0, 16'hFFFF, 1'b1, 1'b0);
        send_word(0, 16'h0001, 1'b0, 1'b1);
        wait_drain(0);

        // Mid-frame reset, with a word offered during reset.
        @(posedge aclk);
        #1;
        send_word(0, 16'h1234, 1'b0, 1'b0);
        base = nxfer[0];
        for (int n = 0; n < 50 && nxfer[0] < base + 2; n++) begin
            @(posedge aclk);
            #1;
        end
        check("two_bytes_before_reset", {31'd0, nxfer[0] == base + 2}, 32'd1);
        rst         = 1'b1;
        s_tvalid[0] = 1'b1;
        s_tdata[0]  = 16'hABCD;
        @(posedge aclk);
        #1;
        check("reset_abort_tvalid", {30'd0, m_tvalid[0], m_tlast[0]}, 32'd0);
        @(posedge aclk);
        #1;
        check("reset_hold_ready", {30'd0, s_tready[0], m_tvalid[0]}, 32'd2);
        rst         = 1'b0;
        s_tvalid[0] = 1'b0;
        @(posedge aclk);
        #1;
        check("no_accept_during_reset", {31'd0, m_tvalid[0]}, 32'd0);
        send_word(0, 16'h0000, 1'b0, 1'b0); wait_drain(0);

        // Randomized words, random stall, random gaps and holds.
        rand_ready = 3'b111;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 25; i++) begin
                send_word(k, 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);
                repeat ($urandom_range(0, 3)) @(posedge aclk);
                #1;
            end
            s_tvalid[k] = 1'b0;
            wait_drain(k);
        end
        rand_ready = 3'b000;
        repeat (4) @(posedge aclk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_hex_ascii_formatter

// File: doc/hex_ascii_formatter.md
HEX_ASCII_FORMATTER -- requirements
Module: hex_ascii_formatter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the result word width; it must be a multiple of 4 and at least 4.
REQ-002 The block SHALL have parameter INCLUDE_CRLF, default 1; when 1, each frame ends with CR LF.
REQ-003 The block SHALL have parameter UPPERCASE, default 1; when 1, hex digits A-F are 8'h41-8'h46, and when 0 they are 8'h61-8'h66.
REQ-004 The block SHALL have port aclk_i, input, 1 bit: the single clock; every flop is on its rising edge.
REQ-005 The block SHALL have port rst_i, input, 1 bit: the reset, which is synchronous and active-high.
REQ-006 The block SHALL have port s_axis_tready_o, output, 1 bit: ready to accept a result word.
REQ-007 The block SHALL have port s_axis_tdata_i, input, DATA_WIDTH bits: the result word from the upstream ALU.
REQ-008 The block SHALL have port s_axis_tvalid_i, input, 1 bit: result word valid.
REQ-009 The block SHALL have port s_axis_tlast_i, input, 1 bit: accepted and ignored.
REQ-010 The block SHALL have port m_axis_tvalid_o, output, 1 bit: ASCII byte valid.
REQ-011 The block SHALL have port m_axis_tdata_o, output, 8 bits: the ASCII byte.
REQ-012 The block SHALL have port m_axis_tlast_o, output, 1 bit: marks the final byte of a frame.
REQ-013 The block SHALL have port m_axis_tready_i, input, 1 bit: downstream ready.

Function
REQ-014 The block SHALL convert each accepted word into a frame of NDIG = DATA_WIDTH/4 ASCII hex digits, most-significant nibble first, followed by 8'h0D and 8'h0A when INCLUDE_CRLF=1.
REQ-015 The block SHALL use a state machine with states IDLE, DIGIT, CR and LF; CR and LF are unreachable when INCLUDE_CRLF=0.
REQ-016 In IDLE, s_axis_tready_o SHALL be 1 and m_axis_tvalid_o SHALL be 0; in every other state, s_axis_tready_o SHALL be 0.
REQ-017 In IDLE, on s_axis_tvalid_i=1 the block SHALL latch s_axis_tdata_i into a word register, set the digit index to NDIG-1, and enter DIGIT on the next cycle.
REQ-018 In DIGIT, m_axis_tvalid_o SHALL be 1 and m_axis_tdata_o SHALL be the ASCII code of the nibble selected by the digit index.
REQ-019 In DIGIT, on a transfer (tvalid & tready) with index > 0, the index SHALL decrement by 1.
REQ-020 In DIGIT, on a transfer with index = 0, the next state SHALL be CR if INCLUDE_CRLF=1, else IDLE.
REQ-021 CR SHALL present 8'h0D and go to LF on a transfer; LF SHALL present 8'h0A and go to IDLE on a transfer.
REQ-022 m_axis_tlast_o SHALL be 1 only on the final frame byte: LF when INCLUDE_CRLF=1, or DIGIT with index 0 when INCLUDE_CRLF=0.
REQ-023 While m_axis_tvalid_o=1 and m_axis_tready_i=0, m_axis_tdata_o, m_axis_tlast_o and the state SHALL hold unchanged; tvalid SHALL never deassert before a transfer.
REQ-024 Latency SHALL be: a word accepted in cycle N has its first digit valid in cycle N+1.
REQ-025 Under continuous m_axis_tready_i, a frame SHALL occupy NDIG(+2) consecutive cycles, and the next word SHALL be accepted in the cycle after the final transfer.
REQ-026 No combinational path SHALL exist from m_axis_tready_i to s_axis_tready_o or to m_axis_tvalid_o; all outputs SHALL decode from registered state only.
REQ-027 The latched word SHALL not change during a frame; s_axis_tdata_i changes outside IDLE SHALL have no effect.

Reset
REQ-028 While rst_i=1 at a clock edge, the block SHALL set state=IDLE, clear the digit index and clear the word register to 0.
REQ-029 The block SHALL drive reset output values: s_axis_tready_o=1, m_axis_tvalid_o=0, m_axis_tlast_o=0, m_axis_tdata_o=8'h00.
REQ-030 A reset asserted mid-frame SHALL abort the frame without emitting tlast; the first post-reset word SHALL produce a complete new frame.
REQ-031 A word offered during a reset cycle SHALL not be accepted.

Structure
REQ-032 Package hex_fmt_pkg SHALL hold the state enum type, constants ASCII_CR=8'h0D and ASCII_LF=8'h0A, and a nibble-to-ASCII function taking an uppercase flag.
REQ-033 The block SHALL contain no sub-module; the nibble conversion SHALL be the package function.
REQ-034 The digit index width SHALL be $clog2(NDIG), minimum 1.

Verification
REQ-035 With defaults and tready held 1, input 16'h1A2F SHALL produce 31 41 32 46 0D 0A with tlast only on 0A.
REQ-036 With UPPERCASE=0, input 16'hBEEF SHALL produce 62 65 65 66 0D 0A.
REQ-037 With INCLUDE_CRLF=0, input 16'h0009 SHALL produce 30 30 30 39 with tlast on 39, after which s_axis_tready_o=1 in the next cycle.
REQ-038 With m_axis_tready_i random at 50% duty, input 16'hC0DE SHALL deliver bytes unchanged and in order, tdata stable while stalled, and s_axis_tready_o=0 throughout the frame.
REQ-039 Asserting rst_i after the second byte of 16'h1234 SHALL give tvalid=0 in the next cycle; a following 16'h0000 SHALL then produce 30 30 30 30 0D 0A.
REQ-040 Back-to-back words 16'hFFFF and 16'h0001 with s_axis_tvalid_i held 1 SHALL give two complete frames, the second word accepted exactly one cycle after the first frame's LF transfer.
